// File: rtl/ffdiv_req_sequencer.sv
// Request sequencer around the iterative FP divider: operand FIFO, one-at-a-time issue,
// registered result capture with measured latency, and running latency statistics.
module ffdiv_req_sequencer #(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned FLAG_SIZE     = 5,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned LAT_WIDTH     = 8,
    parameter int unsigned STAT_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_operand1,
    input  logic [OPERAND_WIDTH-1:0] in_operand2,
    output logic                     div_en,
    output logic [OPERAND_WIDTH-1:0] div_operand1,
    output logic [OPERAND_WIDTH-1:0] div_operand2,
    input  logic                     div_ready,
    input  logic [OPERAND_WIDTH-1:0] div_result,
    input  logic [FLAG_SIZE-1:0]     div_flag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] out_result,
    output logic [FLAG_SIZE-1:0]     out_flag,
    output logic [LAT_WIDTH-1:0]     out_latency,
    input  logic                     stat_clr,
    output logic [STAT_WIDTH-1:0]    stat_op_count,
    output logic [STAT_WIDTH-1:0]    stat_cycle_sum
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] DepthCnt = FIFO_DEPTH[PtrW:0];

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    state_e                         state_q;
    logic [2*OPERAND_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]                  count_q;
    logic [LAT_WIDTH-1:0]           lat_q;

    logic                           full, empty, push, issue, capture;
    logic [STAT_WIDTH-1:0]          op_base, sum_base;
    logic [STAT_WIDTH:0]            sum_ext;

    assign full     = (count_q == DepthCnt);
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // Issue only when the output slot is free or being freed this cycle.
    assign issue    = (state_q == StIdle) && !empty && (!out_valid || out_ready);
    assign capture  = (state_q == StBusy) && div_ready;

    // A coincident clear zeroes the base before the capture is added.
    assign op_base  = stat_clr ? '0 : stat_op_count;
    assign sum_base = stat_clr ? '0 : stat_cycle_sum;
    assign sum_ext  = {1'b0, sum_base} + {{(STAT_WIDTH + 1 - LAT_WIDTH){1'b0}}, lat_q};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {in_operand1, in_operand2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, issue})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            div_en         <= 1'b0;
            div_operand1   <= '0;
            div_operand2   <= '0;
            lat_q          <= '0;
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_flag       <= '0;
            out_latency    <= '0;
            stat_op_count  <= '0;
            stat_cycle_sum <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        {div_operand1, div_operand2} <= fifo_mem[rd_ptr_q];
                        div_en  <= 1'b1;
                        lat_q   <= LAT_WIDTH'(1);
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (div_ready) begin
                        out_result  <= div_result;
                        out_flag    <= div_flag;
                        out_latency <= lat_q;
                        out_valid   <= 1'b1;
                        div_en      <= 1'b0;
                        state_q     <= StGap;
                    end else if (lat_q != '1) begin
                        lat_q <= lat_q + LAT_WIDTH'(1);
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    div_en  <= 1'b0;
                end
            endcase
            if (capture) begin
                stat_op_count  <= op_base + STAT_WIDTH'(1);
                stat_cycle_sum <= sum_ext[STAT_WIDTH] ? '1 : sum_ext[STAT_WIDTH-1:0];
            end else if (stat_clr) begin
                stat_op_count  <= '0;
                stat_cycle_sum <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ffdiv_req_sequencer.sv
// Bench for ffdiv_req_sequencer: queue-based reference model checked every cycle, a simple
// divider-core responder, and directed scenarios with literal expectations.
module tb_ffdiv_req_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LW      = 4;
    localparam int          LAT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_operand1, in_operand2;
    logic        div_en;
    logic [31:0] div_operand1, div_operand2;
    logic        div_ready;
    logic [31:0] div_result;
    logic [4:0]  div_flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flag;
    logic [LW-1:0] out_latency;
    logic        stat_clr;
    logic [31:0] stat_op_count, stat_cycle_sum;

    int checks = 0;
    int failures = 0;

    // Core responder controls
    int         core_lat = 3;
    logic [4:0] core_flag = '0;
    logic       core_rdy = 1'b0;
    logic       spurious = 1'b0;
    int         core_cnt = 0;

    always #5 clk = ~clk;

    ffdiv_req_sequencer #(
        .OPERAND_WIDTH(32),
        .FLAG_SIZE    (5),
        .FIFO_DEPTH   (DEPTH),
        .LAT_WIDTH    (LW),
        .STAT_WIDTH   (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_operand1   (in_operand1),
        .in_operand2   (in_operand2),
        .div_en        (div_en),
        .div_operand1  (div_operand1),
        .div_operand2  (div_operand2),
        .div_ready     (div_ready),
        .div_result    (div_result),
        .div_flag      (div_flag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_flag      (out_flag),
        .out_latency   (out_latency),
        .stat_clr      (stat_clr),
        .stat_op_count (stat_op_count),
        .stat_cycle_sum(stat_cycle_sum)
    );

    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40A0_0000 && b == 32'h4000_0000) return 32'h4020_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
    endfunction

    assign div_result = core_fn(div_operand1, div_operand2);
    assign div_flag   = core_flag;
    assign div_ready  = core_rdy | spurious;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Core: ready is sampled high at the core_lat-th edge after issue.
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n || !div_en) begin
                core_cnt = 0;
                core_rdy = 1'b0;
            end else begin
                core_cnt++;
                core_rdy = (core_cnt == core_lat);
            end
        end
    end

    // Reference model
    logic [63:0] m_fifo[$];
    logic [63:0] m_cur;
    int          m_state;  // 0 waiting to issue, 1 core running, 2 restart gap
    int          m_lat, m_olat;
    logic        m_ov;
    logic [31:0] m_res;
    logic [4:0]  m_flag;
    logic [31:0] m_cnt;
    longint      m_sum;

    task automatic model_reset();
        m_fifo.delete();
        m_cur = '0; m_state = 0; m_lat = 0; m_olat = 0; m_ov = 1'b0;
        m_res = '0; m_flag = '0; m_cnt = '0; m_sum = 0;
    endtask

    task automatic model_step();
        bit room, slot_free, captured;
        room      = m_fifo.size() < DEPTH;
        slot_free = !m_ov || out_ready;
        captured  = 1'b0;
        if (m_ov && out_ready) m_ov = 1'b0;
        case (m_state)
            0: if (m_fifo.size() > 0 && slot_free) begin
                m_cur = m_fifo.pop_front();
                m_lat = 1;
                m_state = 1;
            end
            1: if (div_ready) begin
                m_res = core_fn(m_cur[63:32], m_cur[31:0]);
                m_flag = core_flag;
                m_olat = m_lat;
                m_ov = 1'b1;
                m_state = 2;
                captured = 1'b1;
            end else if (m_lat < LAT_MAX) begin
                m_lat++;
            end
            default: m_state = 0;
        endcase
        if (stat_clr) begin
            m_cnt = '0;
            m_sum = 0;
        end
        if (captured) begin
            m_cnt++;
            m_sum = m_sum + m_olat;
            if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
        end
        if (in_valid && room) m_fifo.push_back({in_operand1, in_operand2});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", 32'(in_ready), 32'(m_fifo.size() < DEPTH));
            chk("div_en", 32'(div_en), 32'(m_state == 1));
            if (m_state == 1) begin
                chk("div_operand1", div_operand1, m_cur[63:32]);
                chk("div_operand2", div_operand2, m_cur[31:0]);
            end
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("out_result", out_result, m_res);
            chk("out_flag", 32'(out_flag), 32'(m_flag));
            chk("out_latency", 32'(out_latency), 32'(m_olat));
            chk("stat_op_count", stat_op_count, m_cnt);
            chk("stat_cycle_sum", stat_cycle_sum, m_sum[31:0]);
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        int n;
        n = 0;
        in_valid = 1'b1; in_operand1 = a; in_operand2 = b;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) chk("push_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic push_once(input logic [31:0] a, input logic [31:0] b, output bit ok);
        in_valid = 1'b1; in_operand1 = a; in_operand2 = b;
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) chk(name, 32'(seen), 32'd1);
    endtask

    task automatic pulse_clr();
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
    endtask

    initial begin
        bit acc [6];
        bit found;
        rst_n = 1'b0; in_valid = 1'b0; in_operand1 = '0; in_operand2 = '0;
        out_ready = 1'b0; stat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_div_en", 32'(div_en), 32'd0);
        chk("rst_div_operand1", div_operand1, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_stat_op_count", stat_op_count, 32'd0);
        @(posedge clk); #1;

        // Single op, latency 3
        core_lat = 3;
        push(32'h40A0_0000, 32'h4000_0000);
        wait_out_valid("single_timeout", 30);
        chk("single_result", out_result, 32'h4020_0000);
        chk("single_flag", 32'(out_flag), 32'd0);
        chk("single_latency", 32'(out_latency), 32'd3);
        chk("single_op_count", stat_op_count, 32'd1);
        chk("single_cycle_sum", stat_cycle_sum, 32'd3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back, latency 2
        pulse_clr();
        core_lat = 2;
        push(32'h3F80_0000, 32'h4040_0000);
        push(32'hC120_0000, 32'h3E80_0000);
        push(32'h4110_0000, 32'hBF00_0000);
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("b2b_op_count", stat_op_count, 32'd3);
        chk("b2b_cycle_sum", stat_cycle_sum, 32'd6);
        @(posedge clk); #1;

        // Backpressure / full FIFO
        pulse_clr();
        out_ready = 1'b0;
        core_lat = 3;
        for (int i = 0; i < 6; i++) push_once(32'h4100_0000 + 32'(i), 32'h4000_0000 + 32'(i), acc[i]);
        for (int i = 0; i < 5; i++) chk("full_accept", 32'(acc[i]), 32'd1);
        chk("full_reject6", 32'(acc[5]), 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("full_hold_valid", 32'(out_valid), 32'd1);
        chk("full_no_reissue", 32'(div_en), 32'd0);
        chk("full_op_count", stat_op_count, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("drain_op_count", stat_op_count, 32'd5);
        chk("drain_cycle_sum", stat_cycle_sum, 32'd15);
        @(posedge clk); #1;

        // Special values pass through; spurious ready in idle is ignored
        core_flag = 5'b00100;
        push(32'h7F80_0000, 32'h0000_0000);
        wait_out_valid("special_timeout", 30);
        chk("special_flag", 32'(out_flag), 32'd4);
        chk("special_result", out_result, core_fn(32'h7F80_0000, 32'h0000_0000));
        @(posedge clk); #1;
        core_flag = '0;
        repeat (4) @(posedge clk);
        #1 spurious = 1'b1;
        @(posedge clk);
        #1 spurious = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
        chk("spurious_op_count", stat_op_count, 32'd6);
        @(posedge clk); #1;

        // Latency saturation with clear coincident with capture
        core_lat = 20;
        push(32'h3F80_0000, 32'h3F80_0000);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            #1;
            if (core_rdy) begin
                stat_clr = 1'b1;
                @(posedge clk);
                #1 stat_clr = 1'b0;
                found = 1'b1;
            end
        end
        if (!found) chk("sat_timeout", 32'(found), 32'd1);
        @(negedge clk);
        chk("sat_out_valid", 32'(out_valid), 32'd1);
        chk("sat_latency", 32'(out_latency), 32'd15);
        chk("sat_op_count", stat_op_count, 32'd1);
        chk("sat_cycle_sum", stat_cycle_sum, 32'd15);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-operation with entries queued
        core_lat = 10;
        push(32'h4000_0000, 32'h4000_0000);
        push(32'h4040_0000, 32'h4000_0000);
        push(32'h4080_0000, 32'h4000_0000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = div_en;
        end
        if (!found) chk("rst_busy_timeout", 32'(found), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_div_en", 32'(div_en), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_div_en_after", 32'(div_en), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_op_count", stat_op_count, 32'd0);
        chk("midrst_cycle_sum", stat_cycle_sum, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
